mfcc_melbank_mac: RTL and testbench
===================================

Name: mfcc_melbank_mac

Overview:
- Mel filterbank accumulation stage of the MFCC chain. Sits between the FFT power-spectrum stage (upstream) and the log/DCT stage (downstream).
- Consumes one frame of power-spectrum bins. For each bin it reads the triangular-filter weight word from the melbank coefficient distributed SDPRAM (OUT_REG=0, combinational read) and accumulates weighted power into NUM_FILT mel-energy accumulators.
- At frame end it streams the NUM_FILT energies out with a valid/ready handshake.

Parameters:
- NUM_BINS, 257, power bins per frame (N_FFT/2+1).
- ADDR_WIDTH, 9, coefficient RAM address width; 2**ADDR_WIDTH >= NUM_BINS.
- NUM_FILT, 26, mel filters; range 2..63.
- IDX_W, 6, filter-index field width.
- PWR_W, 32, power sample width (unsigned).
- COEF_W, 16, weight width, unsigned Q1.(COEF_W-1); ONE = 2**(COEF_W-1).
- ACC_W, 48, accumulator/output width (unsigned).

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- pow_data  in  PWR_W  power of current bin.
- pow_valid  in  1  pow_data valid.
- pow_last  in  1  marks last bin of frame (checked only, not used as delimiter).
- pow_ready  out  1  bin accepted when pow_valid & pow_ready.
- coef_rd_addr  out  ADDR_WIDTH  coefficient RAM read address.
- coef_rd_data  in  1+IDX_W+COEF_W  {vld, idx, w}, valid in the same cycle as the address.
- mel_data  out  ACC_W  mel energy.
- mel_idx  out  IDX_W  filter number of mel_data.
- mel_valid  out  1  output valid.
- mel_last  out  1  with last filter (idx NUM_FILT-1).
- mel_ready  in  1  downstream ready.
- frame_err  out  1  one-cycle pulse on pow_last/bin-count mismatch.

Behaviour:
- Reset (async, rst=1): state ACCUM, bin counter 0, all accumulators 0, pipeline valids 0. Outputs: pow_ready=1, coef_rd_addr=0, mel_data=0, mel_idx=0, mel_valid=0, mel_last=0, frame_err=0. Reset mid-frame or mid-output aborts the frame; no partial output is emitted.
- Address: coef_rd_addr = bin counter (k). Counter increments on each accepted bin and wraps to 0 after NUM_BINS-1.
- Stage 1 (on accept): register P=pow_data and {vld, idx, w}=coef_rd_data.
- Stage 2: hi = (P*w) >> (COEF_W-1); lo = (P*(ONE-w)) >> (COEF_W-1). Both truncated, PWR_W+1 bits. w > ONE is clamped to ONE.
- Stage 3, only if vld=1:
  - acc[idx] += hi, when idx < NUM_FILT.
  - acc[idx-1] += lo, when 1 <= idx <= NUM_FILT.
  - Both updates may occur in the same cycle. Back-to-back bins hitting the same filter must accumulate correctly (single-cycle read-modify-write, no hazard).
  - Addition saturates at 2**ACC_W-1.
  - vld=0: bin ignored.
- Input-to-accumulate latency: 3 cycles.
- Frame check: if pow_last=1 is accepted with k != NUM_BINS-1, or pow_last=0 with k = NUM_BINS-1, pulse frame_err one cycle after acceptance. The counter still governs framing.
- FSM:
  - ACCUM: pow_ready=1. On accepting bin NUM_BINS-1 -> DRAIN.
  - DRAIN: pow_ready=0. Wait 3 cycles for the pipeline to empty -> OUTPUT.
  - OUTPUT: pow_ready=0, mel_valid=1, mel_idx=j, mel_data=acc[j], mel_last=(j==NUM_FILT-1).
    - j advances on mel_valid & mel_ready.
    - mel_data/mel_idx are held stable while mel_ready=0.
    - On the last handshake, clear all accumulators and j -> ACCUM; pow_ready=1 the next cycle.
- Bins presented during DRAIN/OUTPUT are stalled (pow_ready=0), not dropped.

Test Plan (NUM_BINS=8, NUM_FILT=3, ADDR_WIDTH=3, COEF_W=16, ONE=32768):
- Unit weights: RAM bin k = {1, k%4, 32768}, pow_data=100 for all bins. Expect acc0=200 (bins 0,4), acc1=200, acc2=200, idx3 hi ignored; lo only where w<ONE, so 0. Output 200,200,200, mel_last on the third.
- Split weight: bin 2 = {1, 1, 16384}, P=1000, other bins vld=0. Expect mel0=500, mel1=500, mel2=0.
- Back-pressure: hold mel_ready=0 for 5 cycles at j=1. mel_data/mel_idx stay stable, pow_ready=0 throughout. After release, all outputs in order, then pow_ready=1 and the next frame starts from clean (zero) accumulators.
- Saturation: ACC_W=33, P=2**32-1, w=ONE into filter 0 for all 8 bins. Expect mel0=2**33-1.
- Framing: pow_last asserted at bin 5 -> frame_err pulses one cycle. Frame still ends after bin 7, then outputs.
- Reset mid-output: assert rst while j=1 -> mel_valid=0 immediately. After release, a new frame of all-zero power yields mel0..2=0.

Source files
------------

// File: rtl/mfcc_melbank_mac.sv
// Mel filterbank MAC: weights each power bin into two adjacent triangular-filter accumulators, then streams the energies.
// Bin-to-accumulator latency 3 cycles; pow_ready drops from frame end until the last mel word handshakes.
module mfcc_melbank_mac #(
    parameter int NUM_BINS   = 257,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_FILT   = 26,
    parameter int IDX_W      = 6,
    parameter int PWR_W      = 32,
    parameter int COEF_W     = 16,
    parameter int ACC_W      = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PWR_W-1:0]            pow_data,
    input  logic                        pow_valid,
    input  logic                        pow_last,
    output logic                        pow_ready,
    output logic [ADDR_WIDTH-1:0]       coef_rd_addr,
    input  logic [IDX_W+COEF_W:0]       coef_rd_data,
    output logic [ACC_W-1:0]            mel_data,
    output logic [IDX_W-1:0]            mel_idx,
    output logic                        mel_valid,
    output logic                        mel_last,
    input  logic                        mel_ready,
    output logic                        frame_err
);
    localparam int HW = PWR_W + 1;
    localparam int PW = PWR_W + COEF_W;
    localparam logic [COEF_W-1:0] ONE = {1'b1, {(COEF_W-1){1'b0}}};

    typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  bin_cnt;
    logic [1:0]             drain_cnt;
    logic [IDX_W-1:0]       out_idx;
    logic [ACC_W-1:0]       acc     [NUM_FILT];
    logic [ACC_W:0]         acc_sum [NUM_FILT];
    logic [HW-1:0]          acc_add [NUM_FILT];
    logic [ACC_W-1:0]       mel_sel;

    logic                   s1_vld;
    logic [IDX_W-1:0]       s1_idx;
    logic [COEF_W-1:0]      s1_w;
    logic [PWR_W-1:0]       s1_pwr;
    logic                   s2_vld;
    logic [IDX_W-1:0]       s2_idx;
    logic [HW-1:0]          s2_hi, s2_lo;

    logic [COEF_W-1:0]      w_clamp, w_comp;
    logic [PW-1:0]          prod_hi, prod_lo;
    logic                   accept, last_bin, out_fire, out_done;

    assign accept       = pow_valid & pow_ready;
    assign last_bin     = (bin_cnt == ADDR_WIDTH'(NUM_BINS - 1));
    assign out_fire     = mel_valid & mel_ready;
    assign out_done     = out_fire & mel_last;
    assign coef_rd_addr = bin_cnt;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last_bin)   state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2)    state_nxt = OUTPUT;
            OUTPUT:  if (out_done)             state_nxt = ACCUM;
            default:                           state_nxt = ACCUM;
        endcase
    end

    // FSM: outputs
    always_comb begin
        pow_ready = (state == ACCUM);
        mel_valid = (state == OUTPUT);
        mel_idx   = out_idx;
        mel_data  = mel_valid ? mel_sel : '0;
        mel_last  = mel_valid && (out_idx == IDX_W'(NUM_FILT - 1));
    end

    always_comb begin
        mel_sel = '0;
        for (int i = 0; i < NUM_FILT; i++)
            if (out_idx == IDX_W'(i)) mel_sel = acc[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_cnt   <= '0;
            drain_cnt <= '0;
            out_idx   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept && (pow_last != last_bin);
            if (accept)
                bin_cnt <= last_bin ? '0 : bin_cnt + 1'b1;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (out_fire)
                out_idx <= out_done ? '0 : out_idx + 1'b1;
        end
    end

    // Weights above ONE would make the lower-filter share negative.
    always_comb begin
        w_clamp = (s1_w > ONE) ? ONE : s1_w;
        w_comp  = ONE - w_clamp;
        prod_hi = {{COEF_W{1'b0}}, s1_pwr} * {{PWR_W{1'b0}}, w_clamp};
        prod_lo = {{COEF_W{1'b0}}, s1_pwr} * {{PWR_W{1'b0}}, w_comp};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_idx <= '0;
            s1_w   <= '0;
            s1_pwr <= '0;
            s2_vld <= 1'b0;
            s2_idx <= '0;
            s2_hi  <= '0;
            s2_lo  <= '0;
        end else begin
            s1_vld <= accept & coef_rd_data[IDX_W+COEF_W];
            if (accept) begin
                s1_idx <= coef_rd_data[IDX_W+COEF_W-1:COEF_W];
                s1_w   <= coef_rd_data[COEF_W-1:0];
                s1_pwr <= pow_data;
            end
            s2_vld <= s1_vld;
            s2_idx <= s1_idx;
            s2_hi  <= prod_hi[PW-1 -: HW];
            s2_lo  <= prod_lo[PW-1 -: HW];
        end
    end

    // idx and idx-1 never name the same filter, so each accumulator sees at most one addend.
    always_comb begin
        for (int i = 0; i < NUM_FILT; i++) begin
            acc_add[i] = '0;
            if (s2_vld && s2_idx == IDX_W'(i))
                acc_add[i] = s2_hi;
            else if (s2_vld && s2_idx == IDX_W'(i + 1))
                acc_add[i] = s2_lo;
            acc_sum[i] = {1'b0, acc[i]} + {{(ACC_W-PWR_W){1'b0}}, acc_add[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FILT; i++) acc[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_FILT; i++) begin
                if (out_done)
                    acc[i] <= '0;
                else if (s2_vld)
                    acc[i] <= acc_sum[i][ACC_W] ? {ACC_W{1'b1}} : acc_sum[i][ACC_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_mfcc_melbank_mac.sv
// Scoreboard bench for the mel filterbank MAC: 8 bins, 3 filters, 33-bit accumulators.
module tb_mfcc_melbank_mac;
    localparam int NB = 8;
    localparam int NF = 3;
    localparam longint SATMAX = (64'd1 << 33) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pow_data = '0;
    logic        pow_valid = 1'b0;
    logic        pow_last = 1'b0;
    logic        pow_ready;
    logic [2:0]  coef_rd_addr;
    logic [22:0] coef_rd_data;
    logic [32:0] mel_data;
    logic [5:0]  mel_idx;
    logic        mel_valid;
    logic        mel_last;
    logic        mel_ready = 1'b1;
    logic        frame_err;

    typedef struct packed {
        logic [5:0]  idx;
        logic [32:0] data;
    } exp_t;

    exp_t        q[$];
    logic [22:0] ram [NB];
    logic [31:0] pwr [NB];
    logic        errv [NB];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    assign coef_rd_data = ram[coef_rd_addr];

    mfcc_melbank_mac #(
        .NUM_BINS(NB), .ADDR_WIDTH(3), .NUM_FILT(NF), .IDX_W(6),
        .PWR_W(32), .COEF_W(16), .ACC_W(33)
    ) dut (
        .clk(clk), .rst(rst),
        .pow_data(pow_data), .pow_valid(pow_valid), .pow_last(pow_last), .pow_ready(pow_ready),
        .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data),
        .mel_data(mel_data), .mel_idx(mel_idx), .mel_valid(mel_valid), .mel_last(mel_last),
        .mel_ready(mel_ready), .frame_err(frame_err)
    );

    // Output side of the scoreboard: every word that will handshake is popped and checked.
    always @(negedge clk) begin
        if (!rst && mel_valid && mel_ready) begin
            exp_t x;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL mel_unexpected: got idx=%0d data=%0d, required no output", mel_idx, mel_data);
            end else begin
                x = q.pop_front();
                if (mel_data !== x.data || mel_idx !== x.idx || mel_last !== (x.idx == 6'(NF - 1))) begin
                    n_bad++;
                    $display("FAIL mel_word: got idx=%0d data=%0d last=%0b, required idx=%0d data=%0d last=%0b",
                             mel_idx, mel_data, mel_last, x.idx, x.data, (x.idx == 6'(NF - 1)));
                end
            end
        end
    end

    task automatic drive_bin(input logic [31:0] d, input logic last, output logic err);
        int n = 0;
        pow_data = d; pow_valid = 1'b1; pow_last = last;
        while (!pow_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!pow_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL pow_ready_timeout: got pow_ready=0, required 1 within 200 cycles");
        end
        @(posedge clk); #1;
        err = frame_err;
        pow_valid = 1'b0; pow_last = 1'b0;
    endtask

    // Drives one frame and pushes the reference mel energies derived from ram/pwr.
    task automatic run_frame(input int last_pos);
        longint e [NF];
        longint hi, lo;
        int idx, w;
        logic err;
        for (int k = 0; k < NB; k++) begin
            drive_bin(pwr[k], (k == last_pos), err);
            errv[k] = err;
        end
        for (int i = 0; i < NF; i++) e[i] = 0;
        for (int k = 0; k < NB; k++) begin
            if (ram[k][22]) begin
                idx = int'(ram[k][21:16]);
                w   = int'(ram[k][15:0]);
                if (w > 32768) w = 32768;
                hi = (longint'(pwr[k]) * w) >> 15;
                lo = (longint'(pwr[k]) * (32768 - w)) >> 15;
                if (idx < NF) e[idx] = (e[idx] + hi > SATMAX) ? SATMAX : e[idx] + hi;
                if (idx >= 1 && idx <= NF) e[idx-1] = (e[idx-1] + lo > SATMAX) ? SATMAX : e[idx-1] + lo;
            end
        end
        for (int i = 0; i < NF; i++) begin
            exp_t x;
            x.idx = 6'(i); x.data = 33'(e[i]);
            q.push_back(x);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !pow_ready) && n < 500) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_idx1();
        int n = 0;
        while (!(mel_valid && mel_idx == 6'd1) && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic set_unit(input logic [31:0] p);
        for (int k = 0; k < NB; k++) begin
            ram[k] = {1'b1, 6'(k % 4), 16'd32768};
            pwr[k] = p;
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp += 7;
        if (pow_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_pow_ready: got %0b, required 1", pow_ready); end
        if (coef_rd_addr !== 3'd0) begin n_bad++; $display("FAIL rst_addr: got %0d, required 0", coef_rd_addr); end
        if (mel_data !== 33'd0)    begin n_bad++; $display("FAIL rst_mel_data: got %0d, required 0", mel_data); end
        if (mel_idx !== 6'd0)      begin n_bad++; $display("FAIL rst_mel_idx: got %0d, required 0", mel_idx); end
        if (mel_valid !== 1'b0)    begin n_bad++; $display("FAIL rst_mel_valid: got %0b, required 0", mel_valid); end
        if (mel_last !== 1'b0)     begin n_bad++; $display("FAIL rst_mel_last: got %0b, required 0", mel_last); end
        if (frame_err !== 1'b0)    begin n_bad++; $display("FAIL rst_frame_err: got %0b, required 0", frame_err); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unit_weights();
        int nerr = 0;
        set_unit(32'd100);
        run_frame(NB - 1);
        for (int k = 0; k < NB; k++) nerr += int'(errv[k]);
        n_cmp++;
        if (nerr != 0) begin n_bad++; $display("FAIL unit_frame_err: got %0d pulses, required 0", nerr); end
        wait_idle();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL unit_drain: got %0d pending, required 0", q.size()); end
    endtask

    task automatic test_back_pressure();
        set_unit(32'd100);
        run_frame(NB - 1);
        wait_idx1();
        mel_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (mel_valid !== 1'b1 || mel_idx !== 6'd1 || mel_data !== 33'd200 || pow_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold: got valid=%0b idx=%0d data=%0d pow_ready=%0b, required 1/1/200/0",
                         mel_valid, mel_idx, mel_data, pow_ready);
            end
        end
        mel_ready = 1'b1;
        wait_idle();
        n_cmp++;
        if (q.size() != 0 || pow_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_drain: got pending=%0d pow_ready=%0b, required 0/1", q.size(), pow_ready);
        end
    endtask

    task automatic test_split_weight();
        for (int k = 0; k < NB; k++) begin
            ram[k] = {1'b0, 6'd0, 16'd32768};
            pwr[k] = 32'd777;
        end
        ram[2] = {1'b1, 6'd1, 16'd16384};
        pwr[2] = 32'd1000;
        run_frame(NB - 1);
        n_cmp++;
        if (q[0].data !== 33'd500 || q[1].data !== 33'd500 || q[2].data !== 33'd0) begin
            n_bad++; $display("FAIL split_model: got %0d/%0d/%0d, required 500/500/0", q[0].data, q[1].data, q[2].data);
        end
        wait_idle();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL split_drain: got %0d pending, required 0", q.size()); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < NB; k++) begin
            ram[k] = {1'b1, 6'd0, 16'd32768};
            pwr[k] = 32'hFFFF_FFFF;
        end
        run_frame(NB - 1);
        n_cmp++;
        if (q[0].data !== 33'h1_FFFF_FFFF) begin
            n_bad++; $display("FAIL sat_model: got %0d, required %0d", q[0].data, SATMAX);
        end
        wait_idle();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL sat_drain: got %0d pending, required 0", q.size()); end
    endtask

    task automatic test_framing();
        for (int k = 0; k < NB; k++) begin
            ram[k] = {1'b1, 6'(k % 3), 16'(4096 * (k + 1))};
            pwr[k] = 32'(10 * (k + 1));
        end
        run_frame(5);
        for (int k = 0; k < NB; k++) begin
            n_cmp++;
            if (errv[k] !== (k == 5 || k == NB - 1)) begin
                n_bad++; $display("FAIL frame_err_bin%0d: got %0b, required %0b", k, errv[k], (k == 5 || k == NB - 1));
            end
        end
        wait_idle();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL framing_drain: got %0d pending, required 0", q.size()); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NB; k++) begin
            ram[k] = {1'b1, 6'(k % 4), 16'($urandom_range(0, 40000))};
            pwr[k] = $urandom;
        end
        run_frame(NB - 1);
        for (int k = 0; k < NB; k++) pwr[k] = $urandom_range(0, 5000);
        run_frame(NB - 1);
        wait_idle();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got %0d pending, required 0", q.size()); end
    endtask

    task automatic test_reset_mid_output();
        set_unit(32'd100);
        run_frame(NB - 1);
        wait_idx1();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mel_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %0b, required 0", mel_valid); end
        q.delete();
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (pow_ready !== 1'b1 || coef_rd_addr !== 3'd0) begin
            n_bad++; $display("FAIL rst_mid_state: got pow_ready=%0b addr=%0d, required 1/0", pow_ready, coef_rd_addr);
        end
        set_unit(32'd0);
        run_frame(NB - 1);
        wait_idle();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL rst_mid_drain: got %0d pending, required 0", q.size()); end
    endtask

    initial begin
        for (int k = 0; k < NB; k++) begin ram[k] = '0; pwr[k] = '0; errv[k] = 1'b0; end
        test_reset();
        test_unit_weights();
        test_back_pressure();
        test_split_weight();
        test_saturation();
        test_framing();
        test_back_to_back();
        test_reset_mid_output();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
